alu_add: RTL and testbench

- Registered two's-complement integer adder for the ALU datapath.
- Sums source operands rs1 and rs2 into destination rd with one clock of latency.
- Also registers carry, overflow, zero and negative status flags for the branch/flag logic.
- Core is a structural carry-lookahead adder, not a behavioural "+".

---
 rtl/alu_add.sv | 117 +++++++++++
 tb/tb_alu_add.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/alu_add.sv
// Registered two's-complement adder built on a two-level 4-bit carry-lookahead core.
// Optional macro ALU_ADD_SAT_EN clamps rd on signed overflow instead of wrapping.
module alu_add #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic [WIDTH-1:0] rd,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int NB = WIDTH / 4;

    logic [WIDTH-1:0] g_s;
    logic [WIDTH-1:0] p_s;
    logic [WIDTH-1:0] sum_s;
    logic [NB-1:0]    grp_g_s;
    logic [NB-1:0]    grp_p_s;
    logic [NB:0]      blk_c_s;
    logic [WIDTH-1:0] res_s;
    logic             ovf_s;

    logic [WIDTH-1:0] rd_r;
    logic             carry_r;
    logic             overflow_r;
    logic             zero_r;
    logic             negative_r;

    // Carry into block k expressed purely from group generate/propagate, carry-in of block 0 is 0.
    function automatic logic lookahead_carry(input logic [NB-1:0] gg, input logic [NB-1:0] gp,
                                             input int k);
        logic c;
        c = 1'b0;
        for (int j = 0; j < NB; j++) begin
            if (j < k) begin
                c = gg[j] | (gp[j] & c);
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

    assign g_s = rs1 & rs2;
    assign p_s = rs1 ^ rs2;

    genvar b;
    generate
        for (b = 0; b < NB; b++) begin : g_blk
            logic [3:0] bg_s;
            logic [3:0] bp_s;
            logic [3:0] bc_s;
            assign bg_s = g_s[4*b +: 4];
            assign bp_s = p_s[4*b +: 4];
            assign bc_s[0] = blk_c_s[b];
            assign bc_s[1] = bg_s[0] | (bp_s[0] & bc_s[0]);
            assign bc_s[2] = bg_s[1] | (bp_s[1] & bg_s[0]) | (bp_s[1] & bp_s[0] & bc_s[0]);
            assign bc_s[3] = bg_s[2] | (bp_s[2] & bg_s[1]) | (bp_s[2] & bp_s[1] & bg_s[0])
                           | (bp_s[2] & bp_s[1] & bp_s[0] & bc_s[0]);
            assign grp_g_s[b] = bg_s[3] | (bp_s[3] & bg_s[2]) | (bp_s[3] & bp_s[2] & bg_s[1])
                              | (bp_s[3] & bp_s[2] & bp_s[1] & bg_s[0]);
            assign grp_p_s[b] = &bp_s;
            assign sum_s[4*b +: 4] = bp_s ^ bc_s;
        end
    endgenerate

    // Second-level lookahead: block carry-ins plus final carry-out in blk_c_s[NB].
    always_comb begin
        blk_c_s = '0;
        for (int k = 0; k <= NB; k++) begin
            blk_c_s[k] = lookahead_carry(grp_g_s, grp_p_s, k);
        end
    end

    assign ovf_s = (rs1[WIDTH-1] == rs2[WIDTH-1]) && (sum_s[WIDTH-1] != rs1[WIDTH-1]);

    // Result selection: clamp toward the operands' sign on overflow when saturation is built in.
    always_comb begin
        res_s = sum_s;
`ifdef ALU_ADD_SAT_EN
        if (ovf_s) begin
            res_s = rs1[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            res_s = sum_s;
        end
`endif
    end

    // Result and flag registers; flags read 0 under reset since no result is valid yet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_r       <= '0;
            carry_r    <= 1'b0;
            overflow_r <= 1'b0;
            zero_r     <= 1'b0;
            negative_r <= 1'b0;
        end else begin
            rd_r       <= res_s;
            carry_r    <= blk_c_s[NB];
            overflow_r <= ovf_s;
            zero_r     <= (res_s == '0);
            negative_r <= res_s[WIDTH-1];
        end
    end

    assign rd       = rd_r;
    assign carry    = carry_r;
    assign overflow = overflow_r;
    assign zero     = zero_r;
    assign negative = negative_r;

endmodule

// File: tb/tb_alu_add.sv
// Self-checking bench for alu_add: directed corner cases plus random operands against
// an arithmetic reference model (wide signed/unsigned sums, optional saturation).
module tb_alu_add;

    logic        clk;
    logic        reset;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rd;
    logic        carry;
    logic        overflow;
    logic        zero;
    logic        negative;

    int total;
    int bad;

    alu_add #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero),
        .negative (negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] ufull;
        longint      ssum;
        logic        e_ovf;
        logic [31:0] e_rd;
        ufull = {1'b0, a} + {1'b0, b};
        ssum  = longint'($signed(a)) + longint'($signed(b));
        e_ovf = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
        e_rd  = ufull[31:0];
`ifdef ALU_ADD_SAT_EN
        if (ssum > 64'sd2147483647) e_rd = 32'h7FFF_FFFF;
        if (ssum < -64'sd2147483648) e_rd = 32'h8000_0000;
`endif
        cmp({tag, ".rd"}, rd, e_rd);
        cmp({tag, ".carry"}, {31'd0, carry}, {31'd0, ufull[32]});
        cmp({tag, ".overflow"}, {31'd0, overflow}, {31'd0, e_ovf});
        cmp({tag, ".zero"}, {31'd0, zero}, {31'd0, (e_rd == 32'd0)});
        cmp({tag, ".negative"}, {31'd0, negative}, {31'd0, e_rd[31]});
    endtask

    task automatic check_cleared(input string tag);
        cmp({tag, ".rd"}, rd, 32'd0);
        cmp({tag, ".flags"}, {28'd0, carry, overflow, zero, negative}, 32'd0);
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] b, input string tag);
        rs1 = a;
        rs2 = b;
        @(posedge clk);
        #1;
        check_all(tag, a, b);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hold_rd;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        rs1   = 32'd0;
        rs2   = 32'd0;
        #1;
        check_cleared("por");
        @(posedge clk);
        #1;
        check_cleared("por_edge");
        #2 reset = 1'b1;

        step(32'd5, 32'd6, "pre_rst");
        rs1 = 32'd5;
        rs2 = 32'd6;
        #2 reset = 1'b0;
        #1;
        check_cleared("async_rst");
        @(posedge clk);
        #1;
        check_cleared("rst_hold");
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_rst", 32'd5, 32'd6);
        cmp("post_rst_11", rd, 32'd11);

        step(32'd71, 32'd82, "pos_pos");
        cmp("pos_pos_153", rd, 32'd153);
        step(32'd71, -32'sd82, "pos_neg");
        cmp("pos_neg_m11", rd, 32'hFFFF_FFF5);
        step(-32'sd71, 32'd82, "neg_pos");
        step(-32'sd71, -32'sd82, "neg_neg");
        step(32'd71, -32'sd71, "inv_a");
        cmp("inv_a_zero", {31'd0, zero}, 32'd1);
        step(-32'sd71, 32'd71, "inv_b");
        step(32'h7FFF_FFFF, 32'd1, "max_p1");
        step(32'h8000_0000, 32'h8000_0000, "min_min");
        cmp("min_min_ovf", {31'd0, overflow}, 32'd1);
        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, "m1_m1");
        cmp("m1_m1_m2", rd, 32'hFFFF_FFFE);
        step(32'd0, 32'd0, "zero_zero");
        step(32'h8000_0000, 32'hFFFF_FFFF, "min_m1");
        step(32'h0000_000F, 32'h0000_0001, "nibble_carry");
        step(32'h0FFF_FFFF, 32'h0000_0001, "long_prop");

        hold_rd = rd;
        rs1 = $urandom;
        rs2 = $urandom;
        #3;
        cmp("hold_between_edges", rd, hold_rd);

        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) b = -a;
            if (i % 4 == 2) b = {a[31], 31'h7FFF_0000} | $urandom_range(0, 65535);
            step(a, b, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
